// File: rtl/exception_unit.sv
// exception_unit: commit-stage exception/interrupt arbiter driving cp0 writes, pipeline flush and fetch redirect.
// Optional taken-exception counter enabled by defining EXC_STATS_EN.
module exception_unit #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic [31:0] commit_pc,
    input  logic        commit_bd,
    input  logic        commit_adel_if,
    input  logic        commit_ri,
    input  logic        commit_ov,
    input  logic        commit_sys,
    input  logic        commit_bp,
    input  logic        commit_adel_ld,
    input  logic        commit_ades_st,
    input  logic        commit_eret,
    input  logic [31:0] commit_vaddr,
    input  logic        cp0_allow_interrupt,
    input  logic [7:0]  cp0_interrupt_flag,
    input  logic [31:0] cp0_epc,
    output logic        exp_en,
    output logic        exp_badvaddr_en,
    output logic [31:0] exp_badvaddr,
    output logic        exp_bd,
    output logic [4:0]  exp_code,
    output logic [31:0] exp_epc,
    output logic        exl_clean,
    output logic        flush,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc,
    output logic [31:0] exc_count
);
    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        commit_ready_q, commit_ready_d;
    logic        exp_en_q, exp_en_d;
    logic        exp_badvaddr_en_q, exp_badvaddr_en_d;
    logic [31:0] exp_badvaddr_q, exp_badvaddr_d;
    logic        exp_bd_q, exp_bd_d;
    logic [4:0]  exp_code_q, exp_code_d;
    logic [31:0] exp_epc_q, exp_epc_d;
    logic        exl_clean_q, exl_clean_d;
    logic        flush_q, flush_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [4:0]  last_code_q, last_code_d;
    logic        last_bd_q, last_bd_d;

    logic        irq, exc, accept, bv_en;
    logic [4:0]  code;
    logic [31:0] bv, epc;

    assign irq    = cp0_allow_interrupt & |cp0_interrupt_flag;
    assign exc    = irq | commit_adel_if | commit_ri | commit_ov | commit_sys | commit_bp
                  | commit_adel_ld | commit_ades_st;
    assign accept = state_q == IDLE && commit_valid && (exc || commit_eret);

    always_comb begin
        code  = irq            ? 5'd0  :
                commit_adel_if ? 5'd4  :
                commit_ri      ? 5'd10 :
                commit_ov      ? 5'd12 :
                commit_sys     ? 5'd8  :
                commit_bp      ? 5'd9  :
                commit_adel_ld ? 5'd4  : 5'd5;
        // Data address errors only win when nothing above them in priority is raised.
        bv_en = !irq && (commit_adel_if || (!commit_ri && !commit_ov && !commit_sys && !commit_bp
                && (commit_adel_ld || commit_ades_st)));
        bv    = (!irq && commit_adel_if) ? commit_pc : commit_vaddr;
        epc   = commit_bd ? commit_pc - 32'd4 : commit_pc;
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        commit_ready_d    = commit_ready_q;
        exp_en_d          = 1'b0;
        exp_badvaddr_en_d = 1'b0;
        exp_badvaddr_d    = 32'd0;
        exp_bd_d          = 1'b0;
        exp_code_d        = 5'd0;
        exp_epc_d         = 32'd0;
        exl_clean_d       = 1'b0;
        flush_d           = flush_q;
        redirect_valid_d  = redirect_valid_q;
        redirect_pc_d     = redirect_pc_q;
        last_code_d       = last_code_q;
        last_bd_d         = last_bd_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d           = FLUSH;
                cnt_d             = 32'(FLUSH_CYCLES - 1);
                commit_ready_d    = 1'b0;
                flush_d           = 1'b1;
                exp_en_d          = 1'b1;
                exl_clean_d       = !exc;
                exp_code_d        = exc ? code : last_code_q;
                exp_bd_d          = exc ? commit_bd : last_bd_q;
                exp_epc_d         = exc ? epc : cp0_epc;
                exp_badvaddr_en_d = exc && bv_en;
                exp_badvaddr_d    = (exc && bv_en) ? bv : 32'd0;
                redirect_pc_d     = exc ? EXC_VECTOR : cp0_epc;
                last_code_d       = exc ? code : last_code_q;
                last_bd_d         = exc ? commit_bd : last_bd_q;
            end
            FLUSH: if (cnt_q == 32'd0) begin
                state_d          = REDIRECT;
                flush_d          = 1'b0;
                redirect_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 32'd1;
            end
            REDIRECT: if (redirect_ready) begin
                state_d          = IDLE;
                redirect_valid_d = 1'b0;
                commit_ready_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            cnt_q             <= 32'd0;
            commit_ready_q    <= 1'b1;
            exp_en_q          <= 1'b0;
            exp_badvaddr_en_q <= 1'b0;
            exp_badvaddr_q    <= 32'd0;
            exp_bd_q          <= 1'b0;
            exp_code_q        <= 5'd0;
            exp_epc_q         <= 32'd0;
            exl_clean_q       <= 1'b0;
            flush_q           <= 1'b0;
            redirect_valid_q  <= 1'b0;
            redirect_pc_q     <= 32'd0;
            last_code_q       <= 5'd0;
            last_bd_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            commit_ready_q    <= commit_ready_d;
            exp_en_q          <= exp_en_d;
            exp_badvaddr_en_q <= exp_badvaddr_en_d;
            exp_badvaddr_q    <= exp_badvaddr_d;
            exp_bd_q          <= exp_bd_d;
            exp_code_q        <= exp_code_d;
            exp_epc_q         <= exp_epc_d;
            exl_clean_q       <= exl_clean_d;
            flush_q           <= flush_d;
            redirect_valid_q  <= redirect_valid_d;
            redirect_pc_q     <= redirect_pc_d;
            last_code_q       <= last_code_d;
            last_bd_q         <= last_bd_d;
        end
    end

`ifdef EXC_STATS_EN
    logic [31:0] exc_count_q, exc_count_d;
    always_comb exc_count_d = (accept && exc && !(&exc_count_q)) ? exc_count_q + 32'd1 : exc_count_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) exc_count_q <= 32'd0;
        else     exc_count_q <= exc_count_d;
    end
    assign exc_count = exc_count_q;
`else
    assign exc_count = 32'd0;
`endif

    assign commit_ready    = commit_ready_q;
    assign exp_en          = exp_en_q;
    assign exp_badvaddr_en = exp_badvaddr_en_q;
    assign exp_badvaddr    = exp_badvaddr_q;
    assign exp_bd          = exp_bd_q;
    assign exp_code        = exp_code_q;
    assign exp_epc         = exp_epc_q;
    assign exl_clean       = exl_clean_q;
    assign flush           = flush_q;
    assign redirect_valid  = redirect_valid_q;
    assign redirect_pc     = redirect_pc_q;
endmodule
